// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, FSM state and counter types for data_mem_responder
package dmem_pkg;

  localparam int DMEM_AW = 7;
  localparam int DMEM_DW = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef logic [15:0] cnt_t;
  localparam cnt_t CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MIPS data-memory strobe bus (active-low CEN/WEN/OEN)
interface data_mem_responder_if #(
  parameter int AW = dmem_pkg::DMEM_AW,
  parameter int DW = dmem_pkg::DMEM_DW
);

  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  modport master (output CEN, output WEN, output OEN, output A, output D, input Q);
  modport slave  (input CEN, input WEN, input OEN, input A, input D, output Q);

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: one synchronous write port, async CPU and debug read ports
module dmem_array #(
  parameter int AW = dmem_pkg::DMEM_AW,
  parameter int DW = dmem_pkg::DMEM_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [2**AW];

  // No reset on the array: the clear engine in the parent initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata    = mem[raddr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - clear-on-reset data memory responder; DMEM_STATS_EN builds rd_cnt/wr_cnt
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int            AW         = DMEM_AW,
  parameter int            DW         = DMEM_DW,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic                 ready,
  output logic                 err,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DW-1:0]        dbg_data,
  output cnt_t                 rd_cnt,
  output cnt_t                 wr_cnt
);

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic          cpu_sel;
  logic          cpu_rd;
  logic          cpu_wr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] cpu_rdata;

  // cpu_rd includes conflict cycles, so it serves both the Q gate and the read count.
  assign cpu_sel = (state == READY) && !bus.CEN;
  assign cpu_rd  = cpu_sel && !bus.OEN;
  assign cpu_wr  = cpu_sel && !bus.WEN;

  assign we    = (state == CLEAR) || cpu_wr;
  assign waddr = (state == CLEAR) ? clr_ptr : bus.A;
  assign wdata = (state == CLEAR) ? INIT_VALUE : bus.D;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (cpu_rd && cpu_wr) begin
            err <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  dmem_array #(.AW(AW), .DW(DW)) u_array (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (bus.A),
    .rdata    (cpu_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign bus.Q = cpu_rd ? cpu_rdata : '0;

`ifdef DMEM_STATS_EN
  cnt_t rd_q;
  cnt_t wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      if (cpu_rd && rd_q != CNT_MAX) rd_q <= rd_q + 16'd1;
      if (cpu_wr && wr_q != CNT_MAX) wr_q <= wr_q + 16'd1;
    end
  end

  assign rd_cnt = rd_q;
  assign wr_cnt = wr_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
